// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB indicator code path:
// code values, code type, LED channel indices and the code decoder.
package rgb_pkg;

  typedef logic [1:0] rgb_code_t;

  localparam rgb_code_t RGB_OFF   = 2'b00;
  localparam rgb_code_t RGB_OK    = 2'b01;
  localparam rgb_code_t RGB_ALERT = 2'b10;
  localparam rgb_code_t RGB_FAULT = 2'b11;

  localparam int LED_R = 0;
  localparam int LED_G = 1;
  localparam int LED_B = 2;

  // Channel drives indexed by LED_R/LED_G/LED_B.
  function automatic logic [2:0] rgb_decode(
    input rgb_code_t code,
    input logic      pwm_on,
    input logic      phase
  );
    logic [2:0] d;
    d = '0;
    unique case (code)
      RGB_OFF:   d = '0;
      RGB_OK:    d[LED_G] = pwm_on;
      RGB_ALERT: d[LED_R] = pwm_on & phase;
      RGB_FAULT: d = {3{pwm_on & phase}};
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rgb_code_filter.sv
// Synchronises the async code bus and accepts a code once it is stable.
// Ports: clk, rst_n, code_in -> code_cur, code_chg (strobe), accept (comb).
module rgb_code_filter
  import rgb_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rgb_code_t code_in,
  output rgb_code_t code_cur,
  output logic      code_chg,
  output logic      accept
);

  localparam int SW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] STAB_MAX =
    SW'(STABLE_CYCLES - 1);

  rgb_code_t     s1;
  rgb_code_t     s2;
  rgb_code_t     cand;
  logic [SW-1:0] stab_cnt;

  // Same-cycle acceptance; the top uses it to restart the timebase
  // on the very edge code_cur changes.
  assign accept = (s2 == cand) &&
                  (cand != code_cur) &&
                  (stab_cnt == STAB_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= RGB_OFF;
      s2       <= RGB_OFF;
      cand     <= RGB_OFF;
      stab_cnt <= '0;
      code_cur <= RGB_OFF;
      code_chg <= 1'b0;
    end else begin
      s1       <= code_in;
      s2       <= s1;
      code_chg <= accept;
      if (s2 != cand) begin
        cand     <= s2;
        stab_cnt <= '0;
      end else if (accept) begin
        code_cur <= cand;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/rgb_code_led_driver.sv
// RGB code consumer: filter, PWM/blink timebase and registered LED drives.
// Ports: clk, rst_n, code_in -> led_r/g/b, code_cur, code_chg.
module rgb_code_led_driver
  import rgb_pkg::*;
#(
  parameter int PRESC_DIV     = 50,
  parameter int PWM_BITS      = 8,
  parameter int DUTY          = 128,
  parameter int BLINK_FRAMES  = 64,
  parameter int STABLE_CYCLES = 4,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  rgb_code_t code_in,
  output logic      led_r,
  output logic      led_g,
  output logic      led_b,
  output rgb_code_t code_cur,
  output logic      code_chg
);

  localparam int PSW = $clog2(PRESC_DIV);
  localparam int BFW =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW  = PWM_BITS + 1;
  localparam logic [DW-1:0] DUTY_W = DW'(DUTY);
  localparam logic [2:0] INV = {3{ACTIVE_LOW != 0}};

  logic                accept;
  logic [PSW-1:0]      presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BFW-1:0]      blink_cnt;
  logic                blink_phase;
  logic                tick;
  logic                frame_end;
  logic                blink_wrap;
  logic                pwm_on;
  logic [2:0]          drv;

  rgb_code_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .code_in (code_in),
    .code_cur(code_cur),
    .code_chg(code_chg),
    .accept  (accept)
  );

  assign tick       = (presc == PSW'(PRESC_DIV - 1));
  assign frame_end  = tick && (&pwm_cnt);
  assign blink_wrap = frame_end &&
                      (blink_cnt == BFW'(BLINK_FRAMES - 1));
  // Extra bit lets DUTY == 2^PWM_BITS mean always on.
  assign pwm_on     = ({1'b0, pwm_cnt} < DUTY_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (accept) begin
      presc       <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + PSW'(1);
      if (tick) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      if (blink_wrap) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else if (frame_end) begin
        blink_cnt <= blink_cnt + BFW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv <= INV;
    end else begin
      drv <= rgb_decode(code_cur, pwm_on, blink_phase) ^ INV;
    end
  end

  assign led_r = drv[LED_R];
  assign led_g = drv[LED_G];
  assign led_b = drv[LED_B];

endmodule

// File: tb/tb_rgb_code_led_driver.sv
// Scoreboard bench for rgb_code_led_driver with two configurations.
// A: DUTY=4 active-high; B: DUTY=8 (always on) active-low.
module tb_rgb_code_led_driver;

  localparam int PD = 2;
  localparam int PB = 3;
  localparam int BF = 2;
  localparam int SC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] code_in = 2'b01;

  logic       r1, g1, b1, chg1;
  logic       r2, g2, b2, chg2;
  logic [1:0] cur1, cur2;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0] l1;
    logic [2:0] l2;
    logic [1:0] cur;
    logic       chg;
  } exp_t;

  exp_t sbq[$];

  rgb_code_led_driver #(
    .PRESC_DIV(PD), .PWM_BITS(PB), .DUTY(4),
    .BLINK_FRAMES(BF), .STABLE_CYCLES(SC), .ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .code_in(code_in),
    .led_r(r1), .led_g(g1), .led_b(b1),
    .code_cur(cur1), .code_chg(chg1)
  );

  rgb_code_led_driver #(
    .PRESC_DIV(PD), .PWM_BITS(PB), .DUTY(8),
    .BLINK_FRAMES(BF), .STABLE_CYCLES(SC), .ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .code_in(code_in),
    .led_r(r2), .led_g(g2), .led_b(b2),
    .code_cur(cur2), .code_chg(chg2)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, want);
    end
  endtask

  // Expected {r,g,b} from the time cc since the last restart.
  function automatic logic [2:0] ref_led(input int code,
                                         input int cc,
                                         input int duty,
                                         input bit al);
    int pwm;
    int frame;
    bit on;
    bit ph;
    logic [2:0] v;
    pwm   = (cc / PD) % (1 << PB);
    frame = cc / (PD * (1 << PB));
    on    = (pwm < duty);
    ph    = ((frame / BF) % 2) == 0;
    case (code)
      1:       v = {1'b0, on, 1'b0};
      2:       v = {on & ph, 2'b00};
      3:       v = {3{on & ph}};
      default: v = 3'b000;
    endcase
    return v ^ {3{al}};
  endfunction

  // Reference: a code is taken once S+1 equal synced samples are
  // seen and it differs from the current code; acceptance restarts time.
  int p1, p2, run_val, run_len, mcur, mc;

  always @(posedge clk) begin
    exp_t e;
    int d;
    bit acc;
    if (!rst_n) begin
      p1 = 0; p2 = 0; run_val = 0; run_len = 1;
      mcur = 0; mc = 0;
      e.l1 = 3'b000; e.l2 = 3'b111;
      e.cur = 2'b00; e.chg = 1'b0;
    end else begin
      e.l1 = ref_led(mcur, mc, 4, 1'b0);
      e.l2 = ref_led(mcur, mc, 8, 1'b1);
      d  = p2;
      p2 = p1;
      p1 = int'(code_in);
      if (d == run_val) run_len++;
      else begin
        run_val = d;
        run_len = 1;
      end
      acc = (run_len >= SC + 1) && (run_val != mcur);
      if (acc) begin
        mcur = run_val;
        mc = 0;
      end else begin
        mc++;
      end
      e.cur = 2'(mcur);
      e.chg = acc;
    end
    sbq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty t=%0t", $time);
    end else begin
      e = sbq.pop_front();
      check("leds_a", {r1, g1, b1}, e.l1);
      check("leds_b", {r2, g2, b2}, e.l2);
      check("cur_a", cur1, e.cur);
      check("cur_b", cur2, e.cur);
      check("chg_a", chg1, e.chg);
      check("chg_b", chg2, e.chg);
    end
  end

  initial begin
    int hit;
    rst_n = 1'b0;
    code_in = 2'b01;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hit = 0;
    for (int i = 1; i <= 20 && hit == 0; i++) begin
      @(posedge clk);
      #1;
      if (chg1) hit = i;
    end
    check("chg_latency_edge", hit, 6);
    check("cur_after_accept", cur1, 2'b01);
    @(negedge clk);
    repeat (40) @(negedge clk);

    code_in = 2'b10;
    repeat (2) @(negedge clk);
    code_in = 2'b01;
    repeat (40) @(negedge clk);

    code_in = 2'b10;
    repeat (140) @(negedge clk);
    repeat (7) @(negedge clk);
    code_in = 2'b11;
    repeat (80) @(negedge clk);

    repeat (250) begin
      code_in = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 8)) @(negedge clk);
    end

    code_in = 2'b10;
    repeat (43) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_leds_a", {r1, g1, b1}, 3'b000);
    check("async_leds_b", {r2, g2, b2}, 3'b111);
    check("async_cur", cur1, 2'b00);
    check("async_chg", chg1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    code_in = 2'b11;
    repeat (60) @(negedge clk);

    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
